// File: rtl/udp_stream_to_dac.sv
// udp_stream_to_dac: parses Ethernet/IPv4/UDP frames from the 10G MAC RX
// stream, drops anything not addressed to cfg_udp_port, strips the 42-byte
// header and re-packs the payload onto 64-bit beats for the DAC sample path.
module udp_stream_to_dac #(
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_AXIS_TKEEP_WIDTH = 8,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_aresetn,
    input  logic [15:0]                   cfg_udp_port,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s00_axis_tkeep,
    input  logic                          s00_axis_tvalid,
    input  logic                          s00_axis_tlast,
    input  logic                          s00_axis_tuser,
    output logic                          s00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m00_axis_tkeep,
    output logic                          m00_axis_tvalid,
    output logic                          m00_axis_tlast,
    output logic                          m00_axis_tuser,
    input  logic                          m00_axis_tready,
    output logic [C_CNT_WIDTH-1:0]        frames_ok,
    output logic [C_CNT_WIDTH-1:0]        frames_dropped
);

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        FLUSH   = 2'd2,
        DROP    = 2'd3
    } state_t;

    // Number of valid bytes in a (contiguous) tkeep.
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, k[i]};
        end
        return c;
    endfunction

    // Contiguous byte-enable mask of n bytes starting at byte 0 (n <= 8).
    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

    state_t                   state_q, state_d;
    logic [2:0]               beat_q, beat_d;
    logic                     mismatch_q, mismatch_d;
    logic [47:0]              hold_q, hold_d;
    logic [7:0]               flush_keep_q, flush_keep_d;
    logic                     flush_user_q, flush_user_d;
    logic [63:0]              m_tdata_q, m_tdata_d;
    logic [7:0]               m_tkeep_q, m_tkeep_d;
    logic                     m_tvalid_q, m_tvalid_d;
    logic                     m_tlast_q, m_tlast_d;
    logic                     m_tuser_q, m_tuser_d;
    logic [C_CNT_WIDTH-1:0]   frames_ok_q, frames_ok_d;
    logic [C_CNT_WIDTH-1:0]   frames_dropped_q, frames_dropped_d;

    logic                     out_free;
    logic                     s_ready;
    logic                     accept;
    logic [3:0]               v;
    logic                     hdr_fail;
    logic                     mm_now;

    // Next-state, header checks, realignment and output-register loading.
    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        mismatch_d       = mismatch_q;
        hold_d           = hold_q;
        flush_keep_d     = flush_keep_q;
        flush_user_d     = flush_user_q;
        m_tdata_d        = m_tdata_q;
        m_tkeep_d        = m_tkeep_q;
        m_tvalid_d       = m_tvalid_q;
        m_tlast_d        = m_tlast_q;
        m_tuser_d        = m_tuser_q;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;

        out_free = !m_tvalid_q || m00_axis_tready;
        s_ready  = (state_q != FLUSH) && out_free;
        accept   = s00_axis_tvalid && s_ready;
        v        = popcount8(s00_axis_tkeep);

        // Header field checks for the beat currently on the bus.
        hdr_fail = 1'b0;
        case (beat_q)
            3'd1: hdr_fail = (s00_axis_tdata[47:32] != 16'h0008) ||
                             (s00_axis_tdata[55:48] != 8'h45);
            3'd2: hdr_fail = (s00_axis_tdata[63:56] != 8'h11);
            3'd4: hdr_fail = ({s00_axis_tdata[39:32], s00_axis_tdata[47:40]} != cfg_udp_port);
            default: hdr_fail = 1'b0;
        endcase
        mm_now = mismatch_q || hdr_fail;

        // A consumed output beat frees the register unless reloaded below.
        if (out_free) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            m_tuser_d  = 1'b0;
        end

        if (m_tvalid_q && m_tlast_q && m00_axis_tready) begin
            frames_ok_d = frames_ok_q + CNT_ONE;
        end

        case (state_q)
            HDR: begin
                if (accept) begin
                    if (s00_axis_tlast) begin
                        beat_d     = 3'd0;
                        mismatch_d = 1'b0;
                        if ((beat_q == 3'd5) && !mm_now && (v > 4'd2)) begin
                            // Short payload fits entirely in the last header beat.
                            m_tdata_d  = {16'h0000, s00_axis_tdata[63:16]};
                            m_tkeep_d  = keep_mask(v - 4'd2);
                            m_tvalid_d = 1'b1;
                            m_tlast_d  = 1'b1;
                            m_tuser_d  = s00_axis_tuser;
                        end else begin
                            frames_dropped_d = frames_dropped_q + CNT_ONE;
                        end
                    end else if (beat_q < 3'd5) begin
                        beat_d     = beat_q + 3'd1;
                        mismatch_d = mm_now;
                    end else begin
                        beat_d     = 3'd0;
                        mismatch_d = 1'b0;
                        if (mm_now) begin
                            state_d = DROP;
                        end else begin
                            hold_d  = s00_axis_tdata[63:16];
                            state_d = PAYLOAD;
                        end
                    end
                end
            end

            PAYLOAD: begin
                if (accept) begin
                    m_tdata_d  = {s00_axis_tdata[15:0], hold_q};
                    m_tkeep_d  = 8'hFF;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b0;
                    m_tuser_d  = 1'b0;
                    hold_d     = s00_axis_tdata[63:16];
                    if (s00_axis_tlast) begin
                        if (v <= 4'd2) begin
                            m_tkeep_d = keep_mask(v + 4'd6);
                            m_tlast_d = 1'b1;
                            m_tuser_d = s00_axis_tuser;
                            state_d   = HDR;
                        end else begin
                            // Leftover bytes stay in hold for one extra beat.
                            flush_keep_d = keep_mask(v - 4'd2);
                            flush_user_d = s00_axis_tuser;
                            state_d      = FLUSH;
                        end
                    end
                end
            end

            FLUSH: begin
                if (out_free) begin
                    m_tdata_d  = {16'h0000, hold_q};
                    m_tkeep_d  = flush_keep_q;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b1;
                    m_tuser_d  = flush_user_q;
                    state_d    = HDR;
                end
            end

            DROP: begin
                if (accept && s00_axis_tlast) begin
                    frames_dropped_d = frames_dropped_q + CNT_ONE;
                    state_d          = HDR;
                end
            end

            default: state_d = HDR;
        endcase
    end

    // Control state, output register and counters with asynchronous reset.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q          <= HDR;
            beat_q           <= 3'd0;
            mismatch_q       <= 1'b0;
            m_tdata_q        <= 64'd0;
            m_tkeep_q        <= 8'd0;
            m_tvalid_q       <= 1'b0;
            m_tlast_q        <= 1'b0;
            m_tuser_q        <= 1'b0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            mismatch_q       <= mismatch_d;
            m_tdata_q        <= m_tdata_d;
            m_tkeep_q        <= m_tkeep_d;
            m_tvalid_q       <= m_tvalid_d;
            m_tlast_q        <= m_tlast_d;
            m_tuser_q        <= m_tuser_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    // Realignment holding bytes; only read after being loaded in the same frame.
    always_ff @(posedge s00_axis_aclk) begin
        hold_q       <= hold_d;
        flush_keep_q <= flush_keep_d;
        flush_user_q <= flush_user_d;
    end

    assign s00_axis_tready = s_ready;
    assign m00_axis_tdata  = m_tdata_q;
    assign m00_axis_tkeep  = m_tkeep_q;
    assign m00_axis_tvalid = m_tvalid_q;
    assign m00_axis_tlast  = m_tlast_q;
    assign m00_axis_tuser  = m_tuser_q;
    assign frames_ok       = frames_ok_q;
    assign frames_dropped  = frames_dropped_q;

endmodule
